// File: rtl/pp_pipeline_accel_axi_wr_burst_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pp_pipeline_accel_axi_wr_burst_sched
// Purpose  : gmem3 write-side burst scheduler. Splits a frame into 4KB-safe
//            AXI4 bursts, issues AW, runs the W-beat loop and retires B.
// Revision : 1.0 - initial release
// ============================================================================
module pp_pipeline_accel_axi_wr_burst_sched #(
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  input  logic [63:0] base_addr,
  input  logic [18:0] num_beats,
  output logic        m_axi_AWVALID,
  input  logic        m_axi_AWREADY,
  output logic [63:0] m_axi_AWADDR,
  output logic [7:0]  m_axi_AWLEN,
  output logic        loop_start,
  output logic [18:0] loop_beats,
  input  logic        loop_done,
  input  logic        m_axi_BVALID,
  output logic        m_axi_BREADY,
  input  logic [1:0]  m_axi_BRESP,
  output logic        wr_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_AW    = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [18:0] c_max_burst = 19'(MAX_BURST);
  localparam logic [3:0]  c_max_out   = 4'(MAX_OUTSTANDING);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_addr;
  logic [18:0] r_rem;
  logic [8:0]  r_blen;
  logic [7:0]  r_awlen;
  logic [3:0]  r_outstanding;
  logic        r_wr_err;
  logic        r_idle;

  logic [9:0]  w_room;
  logic [18:0] w_blen_full;
  logic        w_aw_ok;
  logic        w_aw_hs;
  logic        w_b_hs;

  // Beats left before the next 4KB boundary (512 beats of 8 bytes per page).
  assign w_room = 10'd512 - {1'b0, r_addr[11:3]};

  always_comb begin
    w_blen_full = c_max_burst;
    if ({9'd0, w_room} < w_blen_full) begin
      w_blen_full = {9'd0, w_room};
    end
    if (r_rem < w_blen_full) begin
      w_blen_full = r_rem;
    end
  end

  assign w_aw_ok = (r_outstanding < c_max_out);
  assign w_aw_hs = (r_state == S_AW) && w_aw_ok && m_axi_AWREADY;
  assign w_b_hs  = m_axi_BVALID && (r_outstanding != 4'd0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    m_axi_AWVALID = 1'b0;
    loop_start    = 1'b0;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_rem == 19'd0) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_AW;
        end
      end
      S_AW: begin
        m_axi_AWVALID = w_aw_ok;
        if (w_aw_hs) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        loop_start = 1'b1;
        if (loop_done) begin
          w_state_nxt = S_CALC;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ap_done     = 1'b1;
        ap_ready    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_addr   <= 64'd0;
      r_rem    <= 19'd0;
      r_blen   <= 9'd0;
      r_awlen  <= 8'd0;
      r_wr_err <= 1'b0;
      r_idle   <= 1'b0;
    end else begin
      r_idle <= (w_state_nxt == S_IDLE);
      if ((r_state == S_IDLE) && ap_start) begin
        r_addr   <= base_addr;
        r_rem    <= num_beats;
        r_wr_err <= 1'b0;
      end
      if ((r_state == S_CALC) && (r_rem != 19'd0)) begin
        r_blen  <= 9'(w_blen_full);
        r_awlen <= 8'(w_blen_full - 19'd1);
      end
      if ((r_state == S_RUN) && loop_done) begin
        r_addr <= r_addr + {52'd0, r_blen, 3'b000};
        r_rem  <= r_rem - {10'd0, r_blen};
      end
      // Error capture wins over the start-time clear (no B can be pending in IDLE).
      if (w_b_hs && (m_axi_BRESP != 2'b00)) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign ap_idle      = r_idle;
  assign m_axi_AWADDR = r_addr;
  assign m_axi_AWLEN  = r_awlen;
  assign loop_beats   = {10'd0, r_blen};
  assign m_axi_BREADY = (r_outstanding != 4'd0);
  assign wr_err       = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_pp_pipeline_accel_axi_wr_burst_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pp_pipeline_accel_axi_wr_burst_sched
// Purpose  : Directed scoreboard bench for the gmem3 write burst scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_pipeline_accel_axi_wr_burst_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_ready, ap_idle;
  logic [63:0] base_addr = 64'd0;
  logic [18:0] num_beats = 19'd0;
  logic        m_axi_AWVALID;
  logic        m_axi_AWREADY = 1'b0;
  logic [63:0] m_axi_AWADDR;
  logic [7:0]  m_axi_AWLEN;
  logic        loop_start;
  logic [18:0] loop_beats;
  logic        loop_done = 1'b0;
  logic        m_axi_BVALID = 1'b0;
  logic        m_axi_BREADY;
  logic [1:0]  m_axi_BRESP = 2'b00;
  logic        wr_err;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_axi_wr_burst_sched #(
    .MAX_BURST       (256),
    .MAX_OUTSTANDING (4)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .ap_idle       (ap_idle),
    .base_addr     (base_addr),
    .num_beats     (num_beats),
    .m_axi_AWVALID (m_axi_AWVALID),
    .m_axi_AWREADY (m_axi_AWREADY),
    .m_axi_AWADDR  (m_axi_AWADDR),
    .m_axi_AWLEN   (m_axi_AWLEN),
    .loop_start    (loop_start),
    .loop_beats    (loop_beats),
    .loop_done     (loop_done),
    .m_axi_BVALID  (m_axi_BVALID),
    .m_axi_BREADY  (m_axi_BREADY),
    .m_axi_BRESP   (m_axi_BRESP),
    .wr_err        (wr_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  logic [18:0] exp_beats[$];

  int   aw_count = 0, b_count = 0, ls_count = 0, done_count = 0, b_pending = 0;
  logic b_en = 1'b1;
  logic aw_mode = 1'b0;
  logic [1:0] bresp_val = 2'b00;
  logic prev_ls = 1'b0, prev_aw_stall = 1'b0;
  logic [63:0] stall_addr = 64'd0;
  logic [7:0]  stall_len = 8'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave responder: inputs change just after the active edge.
  always @(posedge ap_clk) begin
    #1;
    loop_done     = loop_start;
    m_axi_BVALID  = b_en && (b_pending > 0);
    m_axi_BRESP   = bresp_val;
    m_axi_AWREADY = aw_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: handshakes seen at the negedge complete on the following posedge.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      b_pending     = 0;
      prev_ls       = 1'b0;
      prev_aw_stall = 1'b0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", m_axi_AWVALID, 1);
        check("aw_hold_addr", m_axi_AWADDR, stall_addr);
        check("aw_hold_len", m_axi_AWLEN, stall_len);
      end
      prev_aw_stall = m_axi_AWVALID && !m_axi_AWREADY;
      stall_addr    = m_axi_AWADDR;
      stall_len     = m_axi_AWLEN;
      if (m_axi_AWVALID && m_axi_AWREADY) begin
        aw_count++;
        b_pending++;
        check("aw_expected", 64'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) begin
          check("aw_addr", m_axi_AWADDR, exp_addr.pop_front());
          check("aw_len", m_axi_AWLEN, exp_len.pop_front());
        end
      end
      if (m_axi_BVALID && m_axi_BREADY) begin
        b_count++;
        b_pending--;
      end
      if (loop_start && !prev_ls) begin
        ls_count++;
        check("loop_expected", 64'(exp_beats.size() != 0), 1);
        if (exp_beats.size() != 0) begin
          check("loop_beats", loop_beats, exp_beats.pop_front());
        end
      end
      prev_ls = loop_start;
      if (ap_done) done_count++;
    end
  end

  task automatic push_aw(input logic [63:0] a, input logic [7:0] l);
    exp_addr.push_back(a);
    exp_len.push_back(l);
    exp_beats.push_back(19'(l) + 19'd1);
  endtask

  task automatic start(input logic [63:0] b, input logic [18:0] n);
    @(posedge ap_clk); #1;
    base_addr = b;
    num_beats = n;
    ap_start  = 1'b1;
    @(posedge ap_clk); #1;
    ap_start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    @(negedge ap_clk);
    while (!ap_done && cyc < budget) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      cyc++;
    end
    check("done_seen", ap_done, 1);
    check("ready_with_done", ap_ready, ap_done);
  endtask

  task automatic end_frame(input int aw0, input int ls0, input int n_bursts);
    check("aw_count", aw_count - aw0, n_bursts);
    check("loop_count", ls_count - ls0, n_bursts);
    check("aw_queue_empty", exp_addr.size(), 0);
    check("loop_queue_empty", exp_beats.size(), 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("idle_after_done", ap_idle, 1);
    check("done_one_cycle", ap_done, 0);
  endtask

  initial begin
    int cyc, aw0, ls0, b0, d0;
    logic seen;

    // Reset state
    repeat (2) @(negedge ap_clk);
    check("rst_idle", ap_idle, 0);
    check("rst_awvalid", m_axi_AWVALID, 0);
    check("rst_loop_start", loop_start, 0);
    check("rst_bready", m_axi_BREADY, 0);
    check("rst_done", ap_done, 0);
    check("rst_wr_err", wr_err, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("idle_after_rst", ap_idle, 1);

    // Single burst
    aw0 = aw_count; ls0 = ls_count;
    push_aw(64'h1000, 8'd99);
    start(64'h1000, 19'd100);
    wait_done(200, cyc);
    check("f1_wr_err", wr_err, 0);
    end_frame(aw0, ls0, 1);

    // Multi-burst with AWREADY back-pressure
    aw_mode = 1'b1;
    aw0 = aw_count; ls0 = ls_count;
    push_aw(64'h0, 8'd255);
    push_aw(64'h800, 8'd255);
    push_aw(64'h1000, 8'd87);
    start(64'h0, 19'd600);
    wait_done(400, cyc);
    end_frame(aw0, ls0, 3);
    aw_mode = 1'b0;

    // 4KB split
    aw0 = aw_count; ls0 = ls_count;
    push_aw(64'hFF8, 8'd0);
    push_aw(64'h1000, 8'd2);
    start(64'hFF8, 19'd4);
    wait_done(200, cyc);
    end_frame(aw0, ls0, 2);

    // Empty frame
    aw0 = aw_count; ls0 = ls_count;
    start(64'h4000, 19'd0);
    wait_done(50, cyc);
    check("n0_done_latency", cyc, 3);
    end_frame(aw0, ls0, 0);

    // Error response
    bresp_val = 2'd2;
    aw0 = aw_count; ls0 = ls_count;
    push_aw(64'h2000, 8'd3);
    start(64'h2000, 19'd4);
    wait_done(200, cyc);
    check("err_set", wr_err, 1);
    end_frame(aw0, ls0, 1);
    repeat (5) @(negedge ap_clk);
    check("err_held", wr_err, 1);
    bresp_val = 2'd0;

    // Outstanding limit with B stalled
    b_en = 1'b0;
    aw0 = aw_count; ls0 = ls_count; b0 = b_count; d0 = done_count;
    for (int i = 0; i < 8; i++) push_aw(64'(i) * 64'h800, 8'd255);
    start(64'h0, 19'd2048);
    @(negedge ap_clk);
    check("err_cleared", wr_err, 0);
    repeat (60) @(negedge ap_clk);
    check("stall_aw_count", aw_count - aw0, 4);
    check("stall_awvalid", m_axi_AWVALID, 0);
    check("stall_bready", m_axi_BREADY, 1);
    check("stall_no_done", done_count - d0, 0);
    b_en = 1'b1;
    wait_done(600, cyc);
    check("b_count_at_done", b_count - b0, 8);
    check("f4_wr_err", wr_err, 0);
    end_frame(aw0, ls0, 8);

    // Reset during RUN
    push_aw(64'h0, 8'd255);
    push_aw(64'h800, 8'd255);
    push_aw(64'h1000, 8'd87);
    start(64'h0, 19'd600);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge ap_clk);
      seen = loop_start;
    end
    check("reach_run", seen, 1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("abort_idle", ap_idle, 0);
    check("abort_awvalid", m_axi_AWVALID, 0);
    check("abort_awaddr", m_axi_AWADDR, 0);
    check("abort_loop_start", loop_start, 0);
    check("abort_loop_beats", loop_beats, 0);
    check("abort_bready", m_axi_BREADY, 0);
    check("abort_done", ap_done, 0);
    exp_addr.delete();
    exp_len.delete();
    exp_beats.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("idle_after_abort", ap_idle, 1);

    aw0 = aw_count; ls0 = ls_count;
    push_aw(64'h1000, 8'd99);
    start(64'h1000, 19'd100);
    wait_done(200, cyc);
    check("post_abort_err", wr_err, 0);
    end_frame(aw0, ls0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
